// File: rtl/cp0_pkg.sv
// cp0_pkg
// Shared constants for the coprocessor-0 exception slice:
//   - CP0 register numbers used by mtc0/mfc0
//   - ExcCode values written into Cause[6:2]
//   - default exception handler entry address
package cp0_pkg;

    // CP0 register numbers
    localparam logic [4:0] CP0_REG_SR    = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE = 5'd13;
    localparam logic [4:0] CP0_REG_EPC   = 5'd14;
    localparam logic [4:0] CP0_REG_PRID  = 5'd15;

    // Exception codes as carried by the pipeline stages (0 means "no exception")
    localparam logic [3:0] EXC_NONE    = 4'd0;
    localparam logic [3:0] EXC_INT     = 4'd0;
    localparam logic [3:0] EXC_ADEL    = 4'd4;
    localparam logic [3:0] EXC_ADES    = 4'd5;
    localparam logic [3:0] EXC_SYSCALL = 4'd8;
    localparam logic [3:0] EXC_RI      = 4'd10;
    localparam logic [3:0] EXC_OV      = 4'd12;

    // Default exception handler entry point
    localparam logic [31:0] HANDLER_ADDR_DEFAULT = 32'h0000_4180;

endpackage

// File: rtl/cp0_exc_unit_if.sv
// cp0_exc_unit_if
// Bundle between the MA end of the pipeline and coprocessor 0.
//   master : pipeline side, drives the EX/MA exception/control fields
//            and the interrupt lines, receives req/epc/read data/macro PC.
//   slave  : the CP0 exception unit.
// Signals:
//   pc_add4, bd, if_exc, id_exc, ex_exc, ma_exc, cp0_we, cp0_addr,
//   cp0_wdata, is_eret, hw_int          (pipeline -> CP0)
//   req, epc_out, cp0_rdata, macro_pc,
//   handler_pc                          (CP0 -> pipeline)
interface cp0_exc_unit_if;

    logic [31:0] pc_add4;
    logic        bd;
    logic [3:0]  if_exc;
    logic [3:0]  id_exc;
    logic [3:0]  ex_exc;
    logic [3:0]  ma_exc;
    logic        cp0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic        is_eret;
    logic [5:0]  hw_int;

    logic        req;
    logic [31:0] epc_out;
    logic [31:0] cp0_rdata;
    logic [31:0] macro_pc;
    logic [31:0] handler_pc;

    modport master (
        output pc_add4, bd, if_exc, id_exc, ex_exc, ma_exc,
               cp0_we, cp0_addr, cp0_wdata, is_eret, hw_int,
        input  req, epc_out, cp0_rdata, macro_pc, handler_pc
    );

    modport slave (
        input  pc_add4, bd, if_exc, id_exc, ex_exc, ma_exc,
               cp0_we, cp0_addr, cp0_wdata, is_eret, hw_int,
        output req, epc_out, cp0_rdata, macro_pc, handler_pc
    );

endinterface

// File: rtl/cp0_exc_merge.sv
// cp0_exc_merge
// Purely combinational priority merge of the per-stage exception codes.
// The oldest-detected fault wins: IF > ID > EX > MA; 0 when none is set.
// Ports:
//   if_exc, id_exc, ex_exc, ma_exc  in  4   stage exception codes
//   exc_code                        out 4   merged code
module cp0_exc_merge
    import cp0_pkg::*;
(
    input  logic [3:0] if_exc,
    input  logic [3:0] id_exc,
    input  logic [3:0] ex_exc,
    input  logic [3:0] ma_exc,
    output logic [3:0] exc_code
);

    always_comb begin
        exc_code = EXC_NONE;
        if (if_exc != EXC_NONE)
            exc_code = if_exc;
        else if (id_exc != EXC_NONE)
            exc_code = id_exc;
        else if (ex_exc != EXC_NONE)
            exc_code = ex_exc;
        else if (ma_exc != EXC_NONE)
            exc_code = ma_exc;
    end

endmodule

// File: rtl/cp0_exc_unit.sv
// cp0_exc_unit
// Coprocessor 0 at the MA end of the pipeline. Merges stage exception
// codes, samples hardware interrupts, raises the single-cycle flush
// request and holds SR/Cause/EPC/PRId.
// Ports:
//   clk    in   clock, rising edge
//   reset  in   synchronous, active-high
//   bus    slave modport of cp0_exc_unit_if (MA fields in, req/epc/
//          read data/macro PC/handler address out)
module cp0_exc_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEFAULT,
    parameter logic [31:0] PRID_VALUE   = 32'h2024_0707,
    parameter logic [31:0] RESET_PC     = 32'h0000_3000
) (
    input  logic           clk,
    input  logic           reset,
    cp0_exc_unit_if.slave  bus
);

    // SR fields
    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;

    // Cause fields
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;

    logic [31:0] epc;
    logic [31:0] pc_latch;
    logic [31:0] macro_pc;
    logic [31:0] epc_target;
    logic [3:0]  exc_code;
    logic        int_req;
    logic        exc_req;
    logic        req;

    cp0_exc_merge u_merge (
        .if_exc   (bus.if_exc),
        .id_exc   (bus.id_exc),
        .ex_exc   (bus.ex_exc),
        .ma_exc   (bus.ma_exc),
        .exc_code (exc_code)
    );

    // A flushed bubble (pc_add4 == 0) inherits the last real PC, so a
    // fault or interrupt taken on a bubble still reports a sensible EPC.
    assign macro_pc = (bus.pc_add4 != 32'd0) ? (bus.pc_add4 - 32'd4) : pc_latch;

    assign int_req = (|(bus.hw_int & sr_im)) & sr_ie & ~sr_exl;
    assign exc_req = (exc_code != EXC_NONE) & ~sr_exl;
    assign req     = int_req | exc_req;

    // A delay-slot instruction restarts at its branch, one word earlier.
    assign epc_target = (bus.bd ? (macro_pc - 32'd4) : macro_pc) & 32'hFFFF_FFFC;

    assign bus.req        = req;
    assign bus.epc_out    = epc;
    assign bus.macro_pc   = macro_pc;
    assign bus.handler_pc = HANDLER_ADDR;

    // Combinational mfc0 read; values are the ones held before the edge.
    always_comb begin
        bus.cp0_rdata = 32'd0;
        case (bus.cp0_addr)
            CP0_REG_SR:    bus.cp0_rdata = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
            CP0_REG_CAUSE: bus.cp0_rdata = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exc, 2'd0};
            CP0_REG_EPC:   bus.cp0_rdata = epc;
            CP0_REG_PRID:  bus.cp0_rdata = PRID_VALUE;
            default:       bus.cp0_rdata = 32'd0;
        endcase
    end

    // Architectural state. A taken exception cancels the MA instruction,
    // so its mtc0/eret only take effect when req is low. eret is applied
    // after the mtc0 write so its EXL clear wins when both occur together.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im     <= 6'd0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= 6'd0;
            cause_exc <= 5'd0;
            epc       <= 32'd0;
            pc_latch  <= RESET_PC;
        end else begin
            cause_ip <= bus.hw_int;
            if (bus.pc_add4 != 32'd0)
                pc_latch <= macro_pc;

            if (req) begin
                sr_exl    <= 1'b1;
                cause_bd  <= bus.bd;
                cause_exc <= int_req ? {1'b0, EXC_INT} : {1'b0, exc_code};
                epc       <= epc_target;
            end else begin
                if (bus.cp0_we) begin
                    case (bus.cp0_addr)
                        CP0_REG_SR: begin
                            sr_im  <= bus.cp0_wdata[15:10];
                            sr_exl <= bus.cp0_wdata[1];
                            sr_ie  <= bus.cp0_wdata[0];
                        end
                        CP0_REG_EPC: epc <= {bus.cp0_wdata[31:2], 2'b00};
                        default: ;
                    endcase
                end
                if (bus.is_eret)
                    sr_exl <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// tb_cp0_exc_unit
// Directed self-checking bench for cp0_exc_unit. Inputs change 1 time
// unit after a rising edge; outputs are compared before the next edge.
module tb_cp0_exc_unit;
    import cp0_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    cp0_exc_unit_if bus ();

    cp0_exc_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.pc_add4   = 32'd0;
        bus.bd        = 1'b0;
        bus.if_exc    = 4'd0;
        bus.id_exc    = 4'd0;
        bus.ex_exc    = 4'd0;
        bus.ma_exc    = 4'd0;
        bus.cp0_we    = 1'b0;
        bus.cp0_addr  = 5'd0;
        bus.cp0_wdata = 32'd0;
        bus.is_eret   = 1'b0;
        bus.hw_int    = 6'd0;
    endtask

    task automatic read_reg(input logic [4:0] addr, output logic [31:0] val);
        bus.cp0_addr = addr;
        #1;
        val = bus.cp0_rdata;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (bus.req !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_req: got %b expected 0", bus.req);
        end
        checks++;
        if (bus.epc_out !== 32'd0) begin
            errors++; $display("[TB] FAIL reset_epc_out: got %h expected 00000000", bus.epc_out);
        end
        checks++;
        if (bus.macro_pc !== 32'h0000_3000) begin
            errors++; $display("[TB] FAIL reset_macro_pc: got %h expected 00003000", bus.macro_pc);
        end
        read_reg(CP0_REG_SR, v);
        checks++;
        if (v !== 32'd0) begin
            errors++; $display("[TB] FAIL reset_sr: got %h expected 00000000", v);
        end
        read_reg(CP0_REG_CAUSE, v);
        checks++;
        if (v !== 32'd0) begin
            errors++; $display("[TB] FAIL reset_cause: got %h expected 00000000", v);
        end
        read_reg(CP0_REG_PRID, v);
        checks++;
        if (v !== 32'h2024_0707) begin
            errors++; $display("[TB] FAIL prid: got %h expected 20240707", v);
        end
        read_reg(5'd3, v);
        checks++;
        if (v !== 32'd0) begin
            errors++; $display("[TB] FAIL unknown_read: got %h expected 00000000", v);
        end
        checks++;
        if (bus.handler_pc !== 32'h0000_4180) begin
            errors++; $display("[TB] FAIL handler_pc: got %h expected 00004180", bus.handler_pc);
        end
    endtask

    task automatic test_interrupt();
        logic [31:0] v;
        // mtc0 SR = 0x401 : IM[0]=1, IE=1
        idle();
        bus.cp0_we = 1'b1; bus.cp0_addr = CP0_REG_SR; bus.cp0_wdata = 32'h0000_0401;
        tick();
        idle();
        read_reg(CP0_REG_SR, v);
        checks++;
        if (v !== 32'h0000_0401) begin
            errors++; $display("[TB] FAIL int_sr_write: got %h expected 00000401", v);
        end
        bus.pc_add4 = 32'h0000_3004;
        bus.hw_int  = 6'b000001;
        #1;
        checks++;
        if (bus.req !== 1'b1) begin
            errors++; $display("[TB] FAIL int_req: got %b expected 1", bus.req);
        end
        tick();
        bus.pc_add4 = 32'd0;
        bus.hw_int  = 6'd0;
        #1;
        checks++;
        if (bus.req !== 1'b0) begin
            errors++; $display("[TB] FAIL int_req_exl_masked: got %b expected 0", bus.req);
        end
        read_reg(CP0_REG_CAUSE, v);
        checks++;
        if (v !== 32'h0000_0400) begin
            errors++; $display("[TB] FAIL int_cause: got %h expected 00000400", v);
        end
        read_reg(CP0_REG_SR, v);
        checks++;
        if (v !== 32'h0000_0403) begin
            errors++; $display("[TB] FAIL int_sr_exl: got %h expected 00000403", v);
        end
        checks++;
        if (bus.epc_out !== 32'h0000_3000) begin
            errors++; $display("[TB] FAIL int_epc: got %h expected 00003000", bus.epc_out);
        end
        // eret clears EXL; IP sampled as 0 again
        bus.is_eret = 1'b1;
        tick();
        idle();
        read_reg(CP0_REG_SR, v);
        checks++;
        if (v !== 32'h0000_0401) begin
            errors++; $display("[TB] FAIL int_eret_sr: got %h expected 00000401", v);
        end
    endtask

    task automatic test_overflow_bd();
        logic [31:0] v;
        idle();
        bus.pc_add4 = 32'h0000_3010;
        bus.bd      = 1'b1;
        bus.ex_exc  = EXC_OV;
        // cancelled mtc0 EPC must not land
        bus.cp0_we  = 1'b1; bus.cp0_addr = CP0_REG_EPC; bus.cp0_wdata = 32'h1234_5678;
        #1;
        checks++;
        if (bus.req !== 1'b1) begin
            errors++; $display("[TB] FAIL ov_req: got %b expected 1", bus.req);
        end
        tick();
        idle();
        checks++;
        if (bus.epc_out !== 32'h0000_3008) begin
            errors++; $display("[TB] FAIL ov_epc: got %h expected 00003008", bus.epc_out);
        end
        read_reg(CP0_REG_CAUSE, v);
        checks++;
        if (v !== 32'h8000_0030) begin
            errors++; $display("[TB] FAIL ov_cause: got %h expected 80000030", v);
        end
        read_reg(CP0_REG_SR, v);
        checks++;
        if (v[1] !== 1'b1) begin
            errors++; $display("[TB] FAIL ov_exl: got %b expected 1", v[1]);
        end
        bus.is_eret = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_priority();
        logic [31:0] v;
        idle();
        bus.pc_add4 = 32'h0000_3040;
        bus.if_exc  = EXC_ADEL;
        bus.ma_exc  = EXC_ADES;
        #1;
        checks++;
        if (bus.req !== 1'b1) begin
            errors++; $display("[TB] FAIL prio_req: got %b expected 1", bus.req);
        end
        tick();
        idle();
        read_reg(CP0_REG_CAUSE, v);
        checks++;
        if (v !== 32'h0000_0010) begin
            errors++; $display("[TB] FAIL prio_cause: got %h expected 00000010", v);
        end
        checks++;
        if (bus.epc_out !== 32'h0000_303C) begin
            errors++; $display("[TB] FAIL prio_epc: got %h expected 0000303c", bus.epc_out);
        end
        // again with EXL=1: nothing recorded
        bus.pc_add4 = 32'h0000_3080;
        bus.if_exc  = EXC_ADEL;
        bus.ma_exc  = EXC_ADES;
        #1;
        checks++;
        if (bus.req !== 1'b0) begin
            errors++; $display("[TB] FAIL prio_nested_req: got %b expected 0", bus.req);
        end
        tick();
        idle();
        read_reg(CP0_REG_CAUSE, v);
        checks++;
        if (v !== 32'h0000_0010) begin
            errors++; $display("[TB] FAIL prio_nested_cause: got %h expected 00000010", v);
        end
        checks++;
        if (bus.epc_out !== 32'h0000_303C) begin
            errors++; $display("[TB] FAIL prio_nested_epc: got %h expected 0000303c", bus.epc_out);
        end
        bus.is_eret = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_bubble();
        logic [31:0] v;
        idle();
        bus.pc_add4 = 32'h0000_3020;
        tick();
        idle();
        #1;
        checks++;
        if (bus.macro_pc !== 32'h0000_301C) begin
            errors++; $display("[TB] FAIL bubble_macro_pc: got %h expected 0000301c", bus.macro_pc);
        end
        bus.ex_exc = EXC_RI;
        #1;
        checks++;
        if (bus.req !== 1'b1) begin
            errors++; $display("[TB] FAIL bubble_req: got %b expected 1", bus.req);
        end
        tick();
        idle();
        checks++;
        if (bus.epc_out !== 32'h0000_301C) begin
            errors++; $display("[TB] FAIL bubble_epc: got %h expected 0000301c", bus.epc_out);
        end
        read_reg(CP0_REG_CAUSE, v);
        checks++;
        if (v !== 32'h0000_0028) begin
            errors++; $display("[TB] FAIL bubble_cause: got %h expected 00000028", v);
        end
    endtask

    task automatic test_mtc0_eret();
        logic [31:0] v;
        // EXL=1 here from the bubble fault
        idle();
        bus.cp0_we = 1'b1; bus.cp0_addr = CP0_REG_EPC; bus.cp0_wdata = 32'h0000_3007;
        tick();
        idle();
        read_reg(CP0_REG_EPC, v);
        checks++;
        if (v !== 32'h0000_3004) begin
            errors++; $display("[TB] FAIL mtc0_epc: got %h expected 00003004", v);
        end
        // Cause is not writable
        bus.cp0_we = 1'b1; bus.cp0_addr = CP0_REG_CAUSE; bus.cp0_wdata = 32'hFFFF_FFFF;
        tick();
        idle();
        read_reg(CP0_REG_CAUSE, v);
        checks++;
        if (v !== 32'h0000_0028) begin
            errors++; $display("[TB] FAIL mtc0_cause_ignored: got %h expected 00000028", v);
        end
        bus.is_eret = 1'b1;
        #1;
        checks++;
        if (bus.epc_out !== 32'h0000_3004) begin
            errors++; $display("[TB] FAIL eret_epc_before: got %h expected 00003004", bus.epc_out);
        end
        tick();
        idle();
        read_reg(CP0_REG_SR, v);
        checks++;
        if (v !== 32'h0000_0401) begin
            errors++; $display("[TB] FAIL eret_sr: got %h expected 00000401", v);
        end
        checks++;
        if (bus.epc_out !== 32'h0000_3004) begin
            errors++; $display("[TB] FAIL eret_epc_after: got %h expected 00003004", bus.epc_out);
        end
        // mtc0 SR with EXL set plus eret together: eret wins, other bits masked
        bus.cp0_we = 1'b1; bus.cp0_addr = CP0_REG_SR; bus.cp0_wdata = 32'hFFFF_0C03;
        bus.is_eret = 1'b1;
        tick();
        idle();
        read_reg(CP0_REG_SR, v);
        checks++;
        if (v !== 32'h0000_0C01) begin
            errors++; $display("[TB] FAIL eret_mtc0_sr: got %h expected 00000c01", v);
        end
    endtask

    task automatic test_reset_mid_exc();
        logic [31:0] v;
        idle();
        bus.pc_add4 = 32'h0000_3100;
        bus.hw_int  = 6'b000010;
        bus.ex_exc  = EXC_OV;
        #1;
        checks++;
        if (bus.req !== 1'b1) begin
            errors++; $display("[TB] FAIL rst_pre_req: got %b expected 1", bus.req);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        #1;
        checks++;
        if (bus.req !== 1'b0) begin
            errors++; $display("[TB] FAIL rst_req: got %b expected 0", bus.req);
        end
        checks++;
        if (bus.macro_pc !== 32'h0000_3000) begin
            errors++; $display("[TB] FAIL rst_macro_pc: got %h expected 00003000", bus.macro_pc);
        end
        read_reg(CP0_REG_SR, v);
        checks++;
        if (v !== 32'd0) begin
            errors++; $display("[TB] FAIL rst_sr: got %h expected 00000000", v);
        end
        read_reg(CP0_REG_CAUSE, v);
        checks++;
        if (v !== 32'd0) begin
            errors++; $display("[TB] FAIL rst_cause: got %h expected 00000000", v);
        end
        read_reg(CP0_REG_EPC, v);
        checks++;
        if (v !== 32'd0) begin
            errors++; $display("[TB] FAIL rst_epc: got %h expected 00000000", v);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        idle();
        test_reset();
        test_interrupt();
        test_overflow_bd();
        test_priority();
        test_bubble();
        test_mtc0_eret();
        test_reset_mid_exc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
